// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for the execute-stage ALU.
// The decode control block imports this package too, so codes live in one place.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_SLL  = 4'h3;
  localparam logic [3:0] OP_SRL  = 4'h4;
  localparam logic [3:0] OP_SRA  = 4'h5;
  localparam logic [3:0] OP_SLT  = 4'h6;
  localparam logic [3:0] OP_SLTU = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_AND  = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_exec_unit_logic.sv
// Single-cycle combinational datapath for all non-shift operations.
// Unknown and shift codes fall through to ADD; shifts never use this result.
module alu_logic_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);

  // Decode the opcode into the selected arithmetic/logic result
  always_comb begin
    result = a + b;
    unique case (op)
      OP_SUB:  result = a - b;
      OP_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      OP_XOR:  result = a ^ b;
      OP_OR:   result = a | b;
      OP_AND:  result = a & b;
      default: result = a + b;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: one-cycle logic/arithmetic, iterative one-bit-per-cycle
// shifter, registered result over valid/ready handshakes.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic            busy
);

  alu_state_e      state_q, state_d;
  logic [XLEN-1:0] work_q, work_d;
  logic [SHW-1:0]  count_q, count_d;
  logic [3:0]      op_q, op_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;

  logic [XLEN-1:0] logic_result;
  logic [XLEN-1:0] shifted;
  logic [SHW-1:0]  shamt;

  assign shamt = in_b[SHW-1:0];

  alu_logic_unit #(
    .XLEN (XLEN)
  ) u_logic (
    .op     (in_op),
    .a      (in_a),
    .b      (in_b),
    .result (logic_result)
  );

  // One-bit step of the work register in the latched op's direction and fill
  always_comb begin
    shifted = {work_q[XLEN-2:0], 1'b0};
    unique case (op_q)
      OP_SRL:  shifted = {1'b0, work_q[XLEN-1:1]};
      OP_SRA:  shifted = {work_q[XLEN-1], work_q[XLEN-1:1]};
      default: shifted = {work_q[XLEN-2:0], 1'b0};
    endcase
  end

  // Next-state logic for the FSM, shifter and output registers
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    count_d  = count_q;
    op_d     = op_q;
    result_d = result_q;
    zero_d   = zero_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (!is_shift_op(in_op)) begin
            result_d = logic_result;
            zero_d   = (logic_result == '0);
            state_d  = ST_DONE;
          end else if (shamt == '0) begin
            result_d = in_a;
            zero_d   = (in_a == '0);
            state_d  = ST_DONE;
          end else begin
            work_d  = in_a;
            op_d    = in_op;
            count_d = shamt;
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        work_d  = shifted;
        count_d = count_q - SHW'(1);
        // The final step publishes the result directly, saving a cycle
        if (count_q == SHW'(1)) begin
          result_d = shifted;
          zero_d   = (shifted == '0);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      work_q   <= '0;
      count_q  <= '0;
      op_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      count_q  <= count_d;
      op_q     <= op_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign out_result = result_q;
  assign out_zero   = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus random ops
// compared against a plain-arithmetic reference model.
module tb_alu_exec_unit;

  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            out_zero;
  logic            busy;

  int n_checks = 0;
  int n_errors = 0;

  alu_exec_unit #(
    .XLEN (XLEN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: result straight from the operation's arithmetic meaning
  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int k;
    k = int'(b[4:0]);
    case (op)
      4'h2: return a - b;
      4'h3: return a << k;
      4'h4: return a >> k;
      4'h5: return $unsigned($signed(a) >>> k);
      4'h6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h7: return (a < b) ? 32'd1 : 32'd0;
      4'h8: return a ^ b;
      4'h9: return a | b;
      4'hA: return a & b;
      default: return a + b;
    endcase
  endfunction

  // Cycles from accept to first out_valid: one, or one per shifted bit plus one
  function automatic int ref_latency(input logic [3:0] op, input logic [31:0] b);
    if ((op == 4'h3 || op == 4'h4 || op == 4'h5) && b[4:0] != 5'd0) return int'(b[4:0]) + 1;
    return 1;
  endfunction

  // Offer one op at a negedge; leaves the bench at the negedge of cycle N+1
  task automatic offer(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    check_value("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_op    = 4'($urandom);
    in_a     = $urandom;
    in_b     = $urandom;
  endtask

  // Full transaction with out_ready held high
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] exp;
    int          lat;
    int          cyc;
    exp = ref_result(op, a, b);
    lat = ref_latency(op, b);
    out_ready = 1'b1;
    offer(op, a, b);
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      check_value({tag, "_busy"}, {busy, in_ready}, 2'b10);
      @(negedge clk);
      cyc++;
    end
    check_value({tag, "_latency"}, cyc, lat);
    check_value({tag, "_result"}, out_result, exp);
    check_value({tag, "_zero"}, out_zero, exp == 32'd0);
    @(negedge clk);
    check_value({tag, "_idle_after"}, {in_ready, out_valid, busy}, 3'b100);
  endtask

  initial begin
    int          seen;
    logic [3:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 4'h0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_value("reset_outputs", {in_ready, out_valid, busy, out_zero}, 4'b1000);
    check_value("reset_result", out_result, 0);
    rst = 1'b0;

    run_op("add_wrap", 4'h1, 32'hFFFF_FFFF, 32'h1);
    run_op("slt_neg", 4'h6, 32'hFFFF_FFFE, 32'h1);
    run_op("sltu", 4'h7, 32'hFFFF_FFFE, 32'h1);
    run_op("sub", 4'h2, 32'd5, 32'd7);
    run_op("sra31", 4'h5, 32'h8000_0000, 32'd31);
    run_op("srl31", 4'h4, 32'h8000_0000, 32'd31);
    run_op("sll_k0", 4'h3, 32'h1, 32'h20);
    run_op("op_f_add", 4'hF, 32'd3, 32'd4);
    run_op("op_0_add", 4'h0, 32'd10, 32'd20);
    run_op("and", 4'hA, 32'hF0F0_1234, 32'h0FF0_FFFF);
    run_op("or", 4'h9, 32'h1200_0000, 32'h0000_0034);

    // Back-pressure: result held, new offers ignored until consumed
    out_ready = 1'b0;
    offer(4'h8, 32'hF0F0_F0F0, 32'hFFFF_0000);
    check_value("bp_valid_first", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_op    = 4'h1;
      in_a     = 32'd1;
      in_b     = 32'd1;
      check_value("bp_hold", {out_valid, in_ready, busy}, 3'b101);
      check_value("bp_result", out_result, 32'h0F0F_F0F0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_value("bp_released", {in_ready, out_valid}, 2'b10);
    check_value("bp_result_kept", out_result, 32'h0F0F_F0F0);

    // Reset in cycle N+3 of an SLL with k=20 aborts it
    offer(4'h3, 32'h0000_0001, 32'd20);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_value("abort_state", {out_valid, busy, in_ready}, 3'b001);
    check_value("abort_result", out_result, 0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_value("abort_no_result", seen, 0);

    run_op("after_abort", 4'h3, 32'h0000_0003, 32'd4);

    // Random ops with boundary-biased operands
    for (int i = 0; i < 80; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'd0;
        1: ra = 32'h8000_0000;
        2: rb = ra;
        default: ;
      endcase
      run_op("rand", rop, ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
